lfsr_32: RTL and testbench

//   32-bit maximal-length Fibonacci LFSR pseudo-random source.

---
 rtl/lfsr_32_if.sv | 17 +
 rtl/lfsr_32.sv | 47 ++++
 tb/tb_lfsr_32.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_32_if.sv
// lfsr_32_if: control/data bundle for the lfsr_32 pseudo-random source.
// Optional feature macro: LFSR32_SEED_LOAD_EN adds the load/seed_in pair.
// master drives the step/load controls and reads the state word; slave is the LFSR.
interface lfsr_32_if;
    logic        en;
    logic [31:0] rng_out;
`ifdef LFSR32_SEED_LOAD_EN
    logic        load;
    logic [31:0] seed_in;

    modport master (output en, output load, output seed_in, input  rng_out);
    modport slave  (input  en, input  load, input  seed_in, output rng_out);
`else
    modport master (output en, input  rng_out);
    modport slave  (input  en, output rng_out);
`endif
endinterface

// File: rtl/lfsr_32.sv
// lfsr_32: 32-bit maximal-length Fibonacci LFSR, polynomial x^32 + x^22 + x^2 + x + 1.
// Advances one step per enabled clock; the full state is presented as rng_out.
// Optional feature macro: LFSR32_SEED_LOAD_EN enables a synchronous seed load
// (load beats en; a zero seed is replaced by SEED to avoid the all-zero lock-up).
module lfsr_32 #(
    parameter logic [31:0] SEED = 32'hD4A56AAD
) (
    input  logic       clk,
    input  logic       rst,
    lfsr_32_if.slave   bus
);

    logic [31:0] q_q;
    logic [31:0] q_d;
    logic [31:0] step_d;
    logic        fb;

    // Next-state selection: feedback from taps 32,22,2,1, then load/enable priority.
    always_comb begin
        fb     = q_q[31] ^ q_q[21] ^ q_q[1] ^ q_q[0];
        step_d = {q_q[30:0], fb};
        q_d    = q_q;
`ifdef LFSR32_SEED_LOAD_EN
        if (bus.load) begin
            q_d = (bus.seed_in == '0) ? SEED : bus.seed_in;
        end else if (bus.en) begin
            q_d = step_d;
        end
`else
        if (bus.en) begin
            q_d = step_d;
        end
`endif
    end

    // State register: asynchronous active-low reset to SEED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.rng_out = q_q;

endmodule

// File: tb/tb_lfsr_32.sv
// tb_lfsr_32: randomized self-checking bench for lfsr_32 against a behavioural model.
// Build with LFSR32_SEED_LOAD_EN defined to exercise the seed-load feature as well.
module tb_lfsr_32;

    localparam logic [31:0] SEED = 32'hD4A56AAD;
    localparam logic [31:0] TAP_MASK = 32'h80200003;   // bits 31,21,1,0

    typedef logic [31:0][31:0] mat_t;                   // mat[j] = image of basis bit j

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_32_if bus ();

    lfsr_32 #(.SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    bit          cmp_on = 1'b0;
    logic [31:0] exp_q  = SEED;

    // One LFSR step: shift left, new LSB is the parity of the tapped bits.
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return {s[30:0], ^(s & TAP_MASK)};
    endfunction

    function automatic logic [31:0] mat_apply(input mat_t m, input logic [31:0] x);
        logic [31:0] r = '0;
        for (int j = 0; j < 32; j++) if (x[j]) r = r ^ m[j];
        return r;
    endfunction

    function automatic mat_t mat_mul(input mat_t a, input mat_t b);
        mat_t r;
        for (int j = 0; j < 32; j++) r[j] = mat_apply(a, b[j]);
        return r;
    endfunction

    // The step is linear over GF(2); raise its matrix to the power e.
    function automatic mat_t step_pow(input logic [31:0] e);
        mat_t base;
        mat_t res;
        for (int j = 0; j < 32; j++) begin
            base[j] = ref_step(32'd1 << j);
            res[j]  = 32'd1 << j;
        end
        for (int b = 0; b < 32; b++) begin
            if (e[b]) res = mat_mul(base, res);
            base = mat_mul(base, base);
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the state word.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q <= SEED;
        end
`ifdef LFSR32_SEED_LOAD_EN
        else if (bus.load) begin
            exp_q <= (bus.seed_in == 32'd0) ? SEED : bus.seed_in;
        end
`endif
        else if (bus.en) begin
            exp_q <= ref_step(exp_q);
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("stream", bus.rng_out, exp_q);
            checks++;
            if (bus.rng_out === 32'd0) begin
                errors++;
                $display("FAIL nonzero: got %08h expected non-zero at %0t", bus.rng_out, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        mat_t        m;
        int unsigned divs [5] = '{3, 5, 17, 257, 65537};

        bus.en = 1'b0;
`ifdef LFSR32_SEED_LOAD_EN
        bus.load    = 1'b0;
        bus.seed_in = '0;
`endif
        #1 rst = 1'b0;
        #1 check("reset_async", bus.rng_out, 32'hD4A56AAD);
        cmp_on = 1'b1;

        // Reset held, then released with en low.
        repeat (10) @(negedge clk);
        check("reset_hold", bus.rng_out, 32'hD4A56AAD);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_hold", bus.rng_out, 32'hD4A56AAD);

        // First steps.
        check("model_step1", ref_step(SEED), 32'hA94AD55B);
        bus.en = 1'b1;
        @(negedge clk);
        check("step1", bus.rng_out, 32'hA94AD55B);
        @(negedge clk);
        check("step2", bus.rng_out, 32'h5295AAB7);

        // Enable toggling.
        for (int i = 0; i < 40; i++) begin
            bus.en = i[0];
            @(negedge clk);
        end

        // Random enable (and load when present).
        for (int i = 0; i < 2000; i++) begin
            bus.en = 1'($urandom_range(0, 1));
`ifdef LFSR32_SEED_LOAD_EN
            bus.load = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 7))
                0:       bus.seed_in = 32'd0;
                1:       bus.seed_in = 32'd1;
                default: bus.seed_in = $urandom;
            endcase
`endif
            @(negedge clk);
        end

        // 1000 enabled steps, then an asynchronous reset pulse between edges.
`ifdef LFSR32_SEED_LOAD_EN
        bus.load = 1'b0;
`endif
        bus.en = 1'b1;
        repeat (1000) @(negedge clk);
        cmp_on = 1'b0;
        #2 rst = 1'b0;
        #1 check("midrun_reset", bus.rng_out, 32'hD4A56AAD);
        #1 rst = 1'b1;
        cmp_on = 1'b1;
        @(negedge clk);
        check("restart_step1", bus.rng_out, 32'hA94AD55B);

`ifdef LFSR32_SEED_LOAD_EN
        bus.en = 1'b0;
        bus.load = 1'b1;
        bus.seed_in = 32'h00000001;
        @(negedge clk);
        check("load_one", bus.rng_out, 32'h00000001);
        bus.load = 1'b0;
        bus.en = 1'b1;
        @(negedge clk);
        check("load_then_step", bus.rng_out, 32'h00000003);
        bus.en = 1'b0;
        bus.load = 1'b1;
        bus.seed_in = 32'h00000000;
        @(negedge clk);
        check("load_zero_guard", bus.rng_out, 32'hD4A56AAD);
        bus.en = 1'b1;
        bus.seed_in = 32'h12345678;
        @(negedge clk);
        check("load_over_en", bus.rng_out, 32'h12345678);
        bus.load = 1'b0;
        bus.en = 1'b0;
        @(negedge clk);
`endif
        cmp_on = 1'b0;

        // Period of the reference step: returns to SEED at 2^32-1 and at no proper divisor.
        m = step_pow(32'hFFFFFFFF);
        check("period_full", mat_apply(m, SEED), 32'hD4A56AAD);
        for (int k = 0; k < 5; k++) begin
            m = step_pow(32'hFFFFFFFF / divs[k]);
            r = mat_apply(m, SEED);
            checks++;
            if (r === SEED) begin
                errors++;
                $display("FAIL period_div%0d: got %08h expected not %08h", divs[k], r, SEED);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
